// File: rtl/relay_frame_capture.sv
// relay_frame_capture: packs decoded relay-link nibbles into bytes, delimits
// frames (first non-zero nibble opens, 0x00 byte or idle timeout closes) and
// buffers captured bytes in a first-word-fall-through FIFO for the readout side.
module relay_frame_capture #(
  parameter int DEPTH_LOG2     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [3:0]            nib_in,
  input  logic                  nib_valid,
  input  logic                  rd_en,
  input  logic                  clear_ovf,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  frame_active,
  output logic                  frame_done,
  output logic [7:0]            frame_len,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

  state_t              state_q, state_d;
  logic [3:0]          hold_q, hold_d;
  logic [7:0]          byte_cnt_q, byte_cnt_d;
  logic [15:0]         tmo_q, tmo_d;
  logic                done_q, done_d;
  logic [7:0]          len_q, len_d;
  logic                ovf_q, ovf_d;
  logic [DEPTH_LOG2:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]          mem [DEPTH];

  logic [7:0] lo_byte;
  logic       frame_start;
  logic       push_req;
  logic       push_ok;
  logic       pop;

  assign lo_byte      = {hold_q, nib_in};
  assign empty        = (wptr_q == rptr_q);
  assign full         = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                        (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign level        = wptr_q - rptr_q;
  assign rd_data      = mem[rptr_q[DEPTH_LOG2-1:0]];
  assign frame_active = (state_q != S_IDLE);
  assign frame_done   = done_q;
  assign frame_len    = len_q;
  assign overflow     = ovf_q;

  // Frame FSM: nibble pairing, terminator detection and idle timeout.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    tmo_d       = tmo_q;
    done_d      = 1'b0;
    len_d       = len_q;
    frame_start = 1'b0;
    push_req    = 1'b0;
    if (!enable) begin
      // Abort silently: pending nibble dropped, no done pulse.
      state_d = S_IDLE;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (nib_valid && (nib_in != 4'h0)) begin
            hold_d      = nib_in;
            state_d     = S_LO;
            tmo_d       = '0;
            frame_start = 1'b1;
          end
        end
        S_HI, S_LO: begin
          if (nib_valid) begin
            tmo_d = '0;
            if (state_q == S_HI) begin
              hold_d  = nib_in;
              state_d = S_LO;
            end else if (lo_byte == 8'h00) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              len_d   = byte_cnt_q;
            end else begin
              push_req = 1'b1;
              state_d  = S_HI;
            end
          end else begin
            tmo_d = tmo_q + 16'd1;
            if (tmo_d == TMO_LIMIT) begin
              // Timeout close; a held high nibble is simply abandoned.
              state_d = S_IDLE;
              done_d  = 1'b1;
              len_d   = byte_cnt_q;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO pointer, overflow and byte-count next-state logic.
  always_comb begin
    pop     = rd_en && !empty;
    push_ok = push_req && (!full || pop);
    wptr_d  = push_ok ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d  = pop ? (rptr_q + PTR_ONE) : rptr_q;
    ovf_d   = (push_req && !push_ok) || (ovf_q && !clear_ovf);
    byte_cnt_d = byte_cnt_q;
    if (frame_start) begin
      byte_cnt_d = 8'd0;
    end else if (push_ok && (byte_cnt_q != 8'hFF)) begin
      byte_cnt_d = byte_cnt_q + 8'd1;
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      hold_q     <= 4'h0;
      byte_cnt_q <= 8'd0;
      tmo_q      <= 16'd0;
      done_q     <= 1'b0;
      len_q      <= 8'd0;
      ovf_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q[DEPTH_LOG2-1:0]] <= lo_byte;
    end
  end

endmodule

// File: doc/relay_frame_capture.md
Name: relay_frame_capture

Overview:
Downstream consumer of the relay link nibble decoder. Takes the decoded 4-bit nibble stream and its one-cycle "available" strobe, packs nibble pairs into bytes, and delimits frames (start on first non-zero nibble, end on a 0x00 byte or idle timeout). Stores captured bytes in a first-word-fall-through FIFO that the ARM-side SSP readout logic drains, and reports frame length and overflow.

Parameters:
DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 bytes (default 16)
TIMEOUT_CYCLES, 255, clk cycles with no nib_valid inside a frame before the frame is force-closed (1..65535)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  capture enable; high in FAKE_READER/FAKE_TAG modes
nib_in  input  4  decoded nibble
nib_valid  input  1  one-cycle strobe, nib_in valid
rd_en  input  1  pop request from readout side
clear_ovf  input  1  clears overflow flag
rd_data  output  8  FIFO head byte, valid when empty=0
empty  output  1  FIFO empty
full  output  1  FIFO full
level  output  DEPTH_LOG2+1  byte count in FIFO
frame_active  output  1  high while a frame is being captured
frame_done  output  1  one-cycle pulse on frame close
frame_len  output  8  bytes stored for the last closed frame; saturates at 255
overflow  output  1  sticky; byte dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release): state IDLE; FIFO pointers 0; empty=1, full=0, level=0; frame_active=0, frame_done=0, frame_len=0, overflow=0. rd_data is don't-care while empty.
- FSM: IDLE, HI (expect high nibble), LO (expect low nibble, high nibble held).
- IDLE: nib_valid && nib_in!=0 -> hold nib_in as high nibble, go LO, frame_active=1, byte counter=0, timeout counter=0. A zero nibble in IDLE is ignored.
- LO: nib_valid -> byte = {held, nib_in}. If byte==0x00 -> close frame (terminator is not stored). Otherwise push to FIFO, increment byte counter (saturating at 255), go HI.
- HI: nib_valid -> hold nibble, go LO. No zero check on nibbles inside a frame.
- Timeout: in HI or LO, the counter increments on every cycle without nib_valid and clears on nib_valid. Reaching TIMEOUT_CYCLES closes the frame. A pending high nibble in LO is discarded.
- Close frame: frame_done=1 for exactly one cycle (the cycle after the closing event), frame_len=byte counter, frame_active=0, state IDLE.
- enable low: state forced to IDLE, pending nibble discarded, frame_active=0, no frame_done pulse. FIFO contents, frame_len, and overflow are retained. nib_valid is ignored while enable=0.
- FIFO write: registered; the byte appears at rd_data and empty drops the cycle after the LO-state nib_valid.
- FIFO full on write: byte dropped, overflow set. The byte counter does not count dropped bytes.
- FIFO read: rd_en && !empty advances the read pointer; rd_data shows the next byte in the following cycle. rd_en while empty is ignored.
- Simultaneous push and pop: both take effect and level is unchanged.
  - Push while full with a valid pop in the same cycle is accepted, with no overflow.
  - Push while empty with rd_en in the same cycle: push accepted, pop ignored.
- Pointers are DEPTH_LOG2+1 bits and wrap naturally. full = MSBs differ and the rest are equal; empty = pointers equal.
- overflow clears on clear_ovf. A set event in the same cycle as clear_ovf wins, so overflow stays 1.
- frame_done and new-frame start in the same cycle cannot occur: the close cycle returns to IDLE, and the next nibble starts the next frame.

Test Plan:
1. Nibbles c,0,3,a,0,0 with gaps of 16 cycles -> FIFO holds 0xC0, 0x3A; frame_done pulses once; frame_len=2; frame_active falls after the final 0.
2. Nibbles 0,0,f,1 then silence of 300 cycles -> leading zeros ignored; FIFO holds 0xF1; frame_done 255 cycles after the last strobe; frame_len=1.
3. Nibbles 5 then silence -> timeout; nothing stored; frame_len=0; frame_done pulses.
4. With rd_en held low, 18 bytes in one frame (DEPTH_LOG2=4) -> full=1 after 16 bytes, overflow=1, frame_len=16. Then clear_ovf -> overflow=0. Then drain -> bytes are in order and empty=1.
5. Fill the FIFO to 16 bytes, then in the same cycle push byte 0x77 and assert rd_en -> level stays 16, overflow=0, 0x77 is read last.
6. Assert reset low mid-frame with 3 bytes in the FIFO -> all outputs return to their reset values immediately; nibbles after release start a fresh frame.
